// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback arbiter and its result FIFO.
package wb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 5;

    typedef struct packed {
        logic [AW_DEF-1:0]   addr;
        logic [XLEN_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback result FIFO: two write ports (port 0 is older), one read port,
// exposes every slot and an occupancy mask so pending-register lookups can scan it.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr0_en,
    input  entry_t                 wr0_data,
    input  logic                   wr1_en,
    input  entry_t                 wr1_data,
    input  logic                   rd_en,
    output entry_t                 rd_data,
    output logic [CW-1:0]          count,
    output logic [PW-1:0]          head,
    output entry_t [DEPTH-1:0]     entries,
    output logic [DEPTH-1:0]       occupied
);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            pop;
    logic [PW-1:0]   offset;

    assign pop = rd_en && (count != '0);

    // Storage is not reset; occupancy comes only from pointers and count.
    always_ff @(posedge clk_i) begin
        if (wr0_en) mem[wr_ptr] <= wr0_data;
        if (wr1_en) mem[wr_ptr + PW'(1)] <= wr1_data;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            wr_ptr <= wr_ptr + PW'(wr0_en) + PW'(wr1_en);
            count  <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
        end
    end

    always_comb begin
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset      = PW'(i) - rd_ptr;
            occupied[i] = {1'b0, offset} < count;
            entries[i]  = mem[i];
        end
    end

    assign rd_data = mem[rd_ptr];
    assign head    = rd_ptr;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results into the regfile write port via wb_fifo.
// Optional WB_BYPASS_EN: a lone result arriving at an empty FIFO is written in the same cycle.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            alu_valid_i,
    input  logic [AW-1:0]   alu_rd_addr_i,
    input  logic [XLEN-1:0] alu_rd_data_i,
    output logic            alu_ready_o,
    input  logic            lsu_valid_i,
    input  logic [AW-1:0]   lsu_rd_addr_i,
    input  logic [XLEN-1:0] lsu_rd_data_i,
    output logic            lsu_ready_o,
    output logic            rd_wren_o,
    output logic [AW-1:0]   rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic            rs1_pending_o,
    output logic            rs2_pending_o,
    output logic [XLEN-1:0] rs1_fwd_data_o,
    output logic [XLEN-1:0] rs2_fwd_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } entry_t;

    logic [CW-1:0]        count;
    logic [PW-1:0]        head;
    entry_t               head_entry;
    entry_t [DEPTH-1:0]   entries;
    logic [DEPTH-1:0]     occupied;
    logic                 pop;
    logic [CW:0]          free;
    logic                 lsu_acc, alu_acc;
    logic                 byp_lsu, byp_alu;
    logic                 lsu_push, alu_push;
    logic                 wr0_en, wr1_en;
    entry_t               wr0_data, wr1_data;
    logic [PW-1:0]        idx;

    assign pop  = (count != '0);
    assign free = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);

    // LSU has priority: the ALU needs a second free slot whenever the LSU is offering.
    assign lsu_ready_o = free >= (CW+1)'(1);
    assign alu_ready_o = free >= (lsu_valid_i ? (CW+1)'(2) : (CW+1)'(1));

    assign lsu_acc = lsu_valid_i && lsu_ready_o;
    assign alu_acc = alu_valid_i && alu_ready_o;

`ifdef WB_BYPASS_EN
    // Gated by rst_ni so the write port stays quiet while reset is held.
    assign byp_lsu = rst_ni && (count == '0) && lsu_valid_i && !alu_valid_i && (lsu_rd_addr_i != '0);
    assign byp_alu = rst_ni && (count == '0) && alu_valid_i && !lsu_valid_i && (alu_rd_addr_i != '0);
`else
    assign byp_lsu = 1'b0;
    assign byp_alu = 1'b0;
`endif

    // x0 results are accepted but dropped here so they never occupy a slot.
    assign lsu_push = lsu_acc && (lsu_rd_addr_i != '0) && !byp_lsu;
    assign alu_push = alu_acc && (alu_rd_addr_i != '0) && !byp_alu;

    assign wr0_en   = lsu_push || alu_push;
    assign wr0_data = lsu_push ? entry_t'{lsu_rd_addr_i, lsu_rd_data_i}
                               : entry_t'{alu_rd_addr_i, alu_rd_data_i};
    assign wr1_en   = lsu_push && alu_push;
    assign wr1_data = entry_t'{alu_rd_addr_i, alu_rd_data_i};

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (pop),
        .rd_data  (head_entry),
        .count    (count),
        .head     (head),
        .entries  (entries),
        .occupied (occupied)
    );

    always_comb begin
        rd_wren_o = 1'b0;
        rd_addr_o = '0;
        rd_data_o = '0;
        if (pop) begin
            rd_wren_o = 1'b1;
            rd_addr_o = head_entry.addr;
            rd_data_o = head_entry.data;
        end else if (byp_lsu) begin
            rd_wren_o = 1'b1;
            rd_addr_o = lsu_rd_addr_i;
            rd_data_o = lsu_rd_data_i;
        end else if (byp_alu) begin
            rd_wren_o = 1'b1;
            rd_addr_o = alu_rd_addr_i;
            rd_data_o = alu_rd_data_i;
        end
    end

    // Walk oldest to youngest from the head so the last hit is the youngest write.
    always_comb begin
        rs1_pending_o  = 1'b0;
        rs2_pending_o  = 1'b0;
        rs1_fwd_data_o = '0;
        rs2_fwd_data_o = '0;
        idx            = '0;
        for (int a = 0; a < DEPTH; a++) begin
            idx = head + PW'(a);
            if (occupied[idx] && (rs1_addr_i != '0) && (entries[idx].addr == rs1_addr_i)) begin
                rs1_pending_o  = 1'b1;
                rs1_fwd_data_o = entries[idx].data;
            end
            if (occupied[idx] && (rs2_addr_i != '0) && (entries[idx].addr == rs2_addr_i)) begin
                rs2_pending_o  = 1'b1;
                rs2_fwd_data_o = entries[idx].data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a queue-based model of the writeback rules.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_rd_addr_i = '0;
    logic [31:0] alu_rd_data_i = '0;
    logic        alu_ready_o;
    logic        lsu_valid_i = 1'b0;
    logic [4:0]  lsu_rd_addr_i = '0;
    logic [31:0] lsu_rd_data_i = '0;
    logic        lsu_ready_o;
    logic        rd_wren_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [4:0]  rs1_addr_i = '0;
    logic [4:0]  rs2_addr_i = '0;
    logic        rs1_pending_o, rs2_pending_o;
    logic [31:0] rs1_fwd_data_o, rs2_fwd_data_o;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   acc_lsu, acc_alu;

    wb_arbiter #(.DEPTH(DEPTH), .XLEN(32), .AW(5)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .alu_valid_i    (alu_valid_i),
        .alu_rd_addr_i  (alu_rd_addr_i),
        .alu_rd_data_i  (alu_rd_data_i),
        .alu_ready_o    (alu_ready_o),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_rd_addr_i  (lsu_rd_addr_i),
        .lsu_rd_data_i  (lsu_rd_data_i),
        .lsu_ready_o    (lsu_ready_o),
        .rd_wren_o      (rd_wren_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_o      (rd_data_o),
        .rs1_addr_i     (rs1_addr_i),
        .rs2_addr_i     (rs2_addr_i),
        .rs1_pending_o  (rs1_pending_o),
        .rs2_pending_o  (rs2_pending_o),
        .rs1_fwd_data_o (rs1_fwd_data_o),
        .rs2_fwd_data_o (rs2_fwd_data_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int m_free();
        return DEPTH - q.size() + ((q.size() != 0) ? 1 : 0);
    endfunction

    function automatic bit m_byp();
`ifdef WB_BYPASS_EN
        if (!rst_ni || q.size() != 0 || (lsu_valid_i == alu_valid_i)) return 1'b0;
        return lsu_valid_i ? (lsu_rd_addr_i != 0) : (alu_rd_addr_i != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void m_rd(output logic w, output logic [4:0] a, output logic [31:0] d);
        w = 1'b0; a = '0; d = '0;
        if (q.size() != 0) begin
            w = 1'b1; a = q[0].addr; d = q[0].data;
        end else if (m_byp()) begin
            w = 1'b1;
            a = lsu_valid_i ? lsu_rd_addr_i : alu_rd_addr_i;
            d = lsu_valid_i ? lsu_rd_data_i : alu_rd_data_i;
        end
    endfunction

    function automatic void m_fwd(input logic [4:0] r, output logic p, output logic [31:0] d);
        p = 1'b0; d = '0;
        if (r != 0)
            foreach (q[i])
                if (q[i].addr == r) begin
                    p = 1'b1; d = q[i].data;
                end
    endfunction

    // One clock: decide acceptance from the current offers, then apply pop-then-push.
    task automatic tick();
        bit la, aa, byp;
        ent_t le, ae;
        la  = lsu_valid_i && (m_free() >= 1);
        aa  = alu_valid_i && (m_free() >= (lsu_valid_i ? 2 : 1));
        byp = m_byp();
        le  = '{lsu_rd_addr_i, lsu_rd_data_i};
        ae  = '{alu_rd_addr_i, alu_rd_data_i};
        @(posedge clk_i);
        if (q.size() != 0) void'(q.pop_front());
        if (!byp) begin
            if (la && le.addr != 0) q.push_back(le);
            if (aa && ae.addr != 0) q.push_back(ae);
        end
        acc_lsu = la;
        acc_alu = aa;
        @(negedge clk_i);
    endtask

    task automatic drain();
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd7; lsu_rd_data_i = 32'h1111_2222;
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd9; alu_rd_data_i = 32'h3333_4444;
        rs1_addr_i  = 5'd7; rs2_addr_i = 5'd9;
        rst_ni = 1'b0;
        q.delete();
        #1;
        tests++; if (rd_wren_o !== 1'b0) begin fails++; $display("FAIL reset_wren got=%b exp=0", rd_wren_o); end
        tests++; if ({rs1_pending_o, rs2_pending_o} !== 2'b00) begin fails++; $display("FAIL reset_pending got=%b exp=00", {rs1_pending_o, rs2_pending_o}); end
        tests++; if ({alu_ready_o, lsu_ready_o} !== 2'b11) begin fails++; $display("FAIL reset_ready got=%b exp=11", {alu_ready_o, lsu_ready_o}); end
        tests++; if ({rd_addr_o, rd_data_o, rs1_fwd_data_o} !== '0) begin fails++; $display("FAIL reset_zero addr=%0d data=%h fwd=%h", rd_addr_o, rd_data_o, rs1_fwd_data_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        tests++; if (rd_wren_o !== 1'b0) begin fails++; $display("FAIL reset_held_wren got=%b exp=0", rd_wren_o); end
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            tests++; if (rd_wren_o !== 1'b0) begin fails++; $display("FAIL idle_wren cycle=%0d got=%b exp=0", i, rd_wren_o); end
        end
    endtask

    task automatic test_single();
        drain();
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd3; alu_rd_data_i = 32'h1357_9bdf;
        #1;
        tests++; if (alu_ready_o !== 1'b1) begin fails++; $display("FAIL single_ready got=%b exp=1", alu_ready_o); end
`ifdef WB_BYPASS_EN
        tests++; if ({rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd3, 32'h1357_9bdf}) begin fails++; $display("FAIL single_bypass wren=%b addr=%0d data=%h exp 1/3/13579bdf", rd_wren_o, rd_addr_o, rd_data_o); end
`endif
        tick();
        alu_valid_i = 1'b0;
        #1;
`ifdef WB_BYPASS_EN
        tests++; if (rd_wren_o !== 1'b0) begin fails++; $display("FAIL single_after got=%b exp=0", rd_wren_o); end
`else
        tests++; if ({rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd3, 32'h1357_9bdf}) begin fails++; $display("FAIL single_write wren=%b addr=%0d data=%h exp 1/3/13579bdf", rd_wren_o, rd_addr_o, rd_data_o); end
`endif
        tick();
    endtask

    task automatic test_pair();
        drain();
        lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd4; lsu_rd_data_i = 32'h0000_0001;
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd5; alu_rd_data_i = 32'hffff_1357;
        #1;
        tests++; if ({lsu_ready_o, alu_ready_o, rd_wren_o} !== 3'b110) begin fails++; $display("FAIL pair_accept got=%b exp=110", {lsu_ready_o, alu_ready_o, rd_wren_o}); end
        tick();
        lsu_valid_i = 1'b0; alu_valid_i = 1'b0;
        #1;
        tests++; if ({rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd4, 32'h0000_0001}) begin fails++; $display("FAIL pair_first wren=%b addr=%0d data=%h exp 1/4/00000001", rd_wren_o, rd_addr_o, rd_data_o); end
        tick();
        #1;
        tests++; if ({rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd5, 32'hffff_1357}) begin fails++; $display("FAIL pair_second wren=%b addr=%0d data=%h exp 1/5/ffff1357", rd_wren_o, rd_addr_o, rd_data_o); end
        tick();
        #1;
        tests++; if (rd_wren_o !== 1'b0) begin fails++; $display("FAIL pair_done got=%b exp=0", rd_wren_o); end
    endtask

    task automatic test_fill();
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        bit          saw_full = 1'b0;
        drain();
        acc_lsu = 1'b1; acc_alu = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (acc_lsu) begin lsu_rd_addr_i = 5'($urandom_range(1, 31)); lsu_rd_data_i = $urandom; end
            if (acc_alu) begin alu_rd_addr_i = 5'($urandom_range(1, 31)); alu_rd_data_i = $urandom; end
            lsu_valid_i = 1'b1; alu_valid_i = 1'b1;
            #1;
            m_rd(ew, ea, ed);
            tests++; if (lsu_ready_o !== (m_free() >= 1)) begin fails++; $display("FAIL fill_lsu_ready c=%0d got=%b count=%0d", c, lsu_ready_o, q.size()); end
            tests++; if (alu_ready_o !== (m_free() >= 2)) begin fails++; $display("FAIL fill_alu_ready c=%0d got=%b count=%0d", c, alu_ready_o, q.size()); end
            tests++; if ({rd_wren_o, rd_addr_o, rd_data_o} !== {ew, ea, ed}) begin fails++; $display("FAIL fill_rd c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, rd_wren_o, rd_addr_o, rd_data_o, ew, ea, ed); end
            if (q.size() == DEPTH) begin
                saw_full = 1'b1;
                tests++; if ({alu_ready_o, lsu_ready_o} !== 2'b01) begin fails++; $display("FAIL fill_full_ready c=%0d got=%b exp=01", c, {alu_ready_o, lsu_ready_o}); end
            end
            tick();
        end
        tests++; if (!saw_full) begin fails++; $display("FAIL fill_reached_full got=0 exp=1"); end
        lsu_valid_i = 1'b0; alu_valid_i = 1'b0;
        for (int c = 0; c < DEPTH + 1; c++) begin
            #1;
            m_rd(ew, ea, ed);
            tests++; if ({rd_wren_o, rd_addr_o, rd_data_o} !== {ew, ea, ed}) begin fails++; $display("FAIL fill_drain c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, rd_wren_o, rd_addr_o, rd_data_o, ew, ea, ed); end
            tick();
        end
    endtask

    task automatic test_x0();
        drain();
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd0; alu_rd_data_i = 32'h0000_0246;
        rs1_addr_i = 5'd0;
        #1;
        tests++; if ({alu_ready_o, rd_wren_o, rs1_pending_o} !== 3'b100) begin fails++; $display("FAIL x0_offer got=%b exp=100", {alu_ready_o, rd_wren_o, rs1_pending_o}); end
        tick();
        alu_valid_i = 1'b0;
        #1;
        tests++; if ({rd_wren_o, rs1_pending_o} !== 2'b00) begin fails++; $display("FAIL x0_after got=%b exp=00", {rd_wren_o, rs1_pending_o}); end
        tests++; if ({alu_ready_o, lsu_ready_o} !== 2'b11) begin fails++; $display("FAIL x0_noslot got=%b exp=11", {alu_ready_o, lsu_ready_o}); end
        tick();
    endtask

    task automatic test_fwd_reset();
        drain();
        lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd8; lsu_rd_data_i = 32'h0000_0246;
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd8; alu_rd_data_i = 32'h1317_131f;
        rs1_addr_i = 5'd8; rs2_addr_i = 5'd12;
        #1;
        tests++; if (rs1_pending_o !== 1'b0) begin fails++; $display("FAIL fwd_offered got=%b exp=0", rs1_pending_o); end
        tick();
        lsu_valid_i = 1'b0; alu_valid_i = 1'b0;
        #1;
        tests++; if ({rs1_pending_o, rs1_fwd_data_o} !== {1'b1, 32'h1317_131f}) begin fails++; $display("FAIL fwd_rs1 got=%b/%h exp=1/1317131f", rs1_pending_o, rs1_fwd_data_o); end
        tests++; if ({rs2_pending_o, rs2_fwd_data_o} !== {1'b0, 32'h0}) begin fails++; $display("FAIL fwd_rs2 got=%b/%h exp=0/0", rs2_pending_o, rs2_fwd_data_o); end
        tests++; if ({rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd8, 32'h0000_0246}) begin fails++; $display("FAIL fwd_head got=%b/%0d/%h exp=1/8/00000246", rd_wren_o, rd_addr_o, rd_data_o); end
        rst_ni = 1'b0;
        q.delete();
        #1;
        tests++; if ({rs1_pending_o, rs1_fwd_data_o, rd_wren_o} !== '0) begin fails++; $display("FAIL rst_mid pend=%b fwd=%h wren=%b exp all 0", rs1_pending_o, rs1_fwd_data_o, rd_wren_o); end
        @(posedge clk_i); #1;
        tests++; if (rd_wren_o !== 1'b0) begin fails++; $display("FAIL rst_mid_edge got=%b exp=0", rd_wren_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        tests++; if ({rd_wren_o, rs1_pending_o} !== 2'b00) begin fails++; $display("FAIL rst_release got=%b exp=00", {rd_wren_o, rs1_pending_o}); end
        tick();
        #1;
        tests++; if (rd_wren_o !== 1'b0) begin fails++; $display("FAIL rst_no_x8 got=%b exp=0", rd_wren_o); end
        tick();
    endtask

    task automatic test_random();
        logic        ew, p1, p2;
        logic [4:0]  ea;
        logic [31:0] ed, f1, f2;
        drain();
        acc_lsu = 1'b0; acc_alu = 1'b0;
        for (int c = 0; c < 400; c++) begin
            // An offer that was not accepted is held unchanged.
            if (!lsu_valid_i || acc_lsu) begin
                lsu_valid_i   = ($urandom_range(0, 2) != 0);
                lsu_rd_addr_i = 5'($urandom_range(0, 7));
                lsu_rd_data_i = $urandom;
            end
            if (!alu_valid_i || acc_alu) begin
                alu_valid_i   = ($urandom_range(0, 2) != 0);
                alu_rd_addr_i = 5'($urandom_range(0, 7));
                alu_rd_data_i = $urandom;
            end
            rs1_addr_i = 5'($urandom_range(0, 7));
            rs2_addr_i = 5'($urandom_range(0, 7));
            #1;
            m_rd(ew, ea, ed);
            m_fwd(rs1_addr_i, p1, f1);
            m_fwd(rs2_addr_i, p2, f2);
            tests++; if ({lsu_ready_o, alu_ready_o} !== {m_free() >= 1, m_free() >= (lsu_valid_i ? 2 : 1)}) begin fails++; $display("FAIL rnd_ready c=%0d got=%b count=%0d lv=%b", c, {lsu_ready_o, alu_ready_o}, q.size(), lsu_valid_i); end
            tests++; if ({rd_wren_o, rd_addr_o, rd_data_o} !== {ew, ea, ed}) begin fails++; $display("FAIL rnd_rd c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, rd_wren_o, rd_addr_o, rd_data_o, ew, ea, ed); end
            tests++; if ({rs1_pending_o, rs1_fwd_data_o} !== {p1, f1}) begin fails++; $display("FAIL rnd_rs1 c=%0d rs=%0d got=%b/%h exp=%b/%h", c, rs1_addr_i, rs1_pending_o, rs1_fwd_data_o, p1, f1); end
            tests++; if ({rs2_pending_o, rs2_fwd_data_o} !== {p2, f2}) begin fails++; $display("FAIL rnd_rs2 c=%0d rs=%0d got=%b/%h exp=%b/%h", c, rs2_addr_i, rs2_pending_o, rs2_fwd_data_o, p2, f2); end
            tick();
        end
        drain();
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_single();
        test_pair();
        test_fill();
        test_x0();
        test_fwd_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
